// File: rtl/vote_pkg.sv
// ----------------------------------------------------------------------------
// vote_pkg
// Shared definitions for the weighted-voter session controller slice:
// session state encoding, voter weight constants and datapath widths.
// No ports (package).
// ----------------------------------------------------------------------------
package vote_pkg;

    localparam int TALLY_W = 8;
    localparam int CNT_W   = 16;

    localparam logic [TALLY_W-1:0] W_NP      = 8'd1;
    localparam logic [TALLY_W-1:0] W_VIP     = 8'd4;
    localparam logic [TALLY_W-1:0] W_VVIP    = 8'd16;
    localparam logic [TALLY_W-1:0] MAX_TALLY = 8'd80;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_OPEN  = 2'd2,
        ST_DONE  = 2'd3
    } vote_state_t;

endpackage

// File: rtl/vote_session_ctrl_if.sv
// ----------------------------------------------------------------------------
// vote_session_ctrl_if
// Bundles the host/voter-facing signals of vote_session_ctrl.
//   master : host side  (drives start, result, ack; observes status/verdict)
//   slave  : controller (samples start, result, ack; drives status/verdict)
// Signals: start, result[7:0], ack, clear_votes, open, done, pass, fail, err,
//          final_tally[7:0], elapsed[15:0], and rise_cnt[7:0] when
//          VOTE_STATS_EN is defined.
// ----------------------------------------------------------------------------
interface vote_session_ctrl_if;
    import vote_pkg::*;

    logic               start;
    logic [TALLY_W-1:0] result;
    logic               ack;
    logic               clear_votes;
    logic               open;
    logic               done;
    logic               pass;
    logic               fail;
    logic               err;
    logic [TALLY_W-1:0] final_tally;
    logic [CNT_W-1:0]   elapsed;
`ifdef VOTE_STATS_EN
    logic [7:0]         rise_cnt;
`endif

    modport master (
        output start, result, ack,
        input  clear_votes, open, done, pass, fail, err, final_tally, elapsed
`ifdef VOTE_STATS_EN
        , input rise_cnt
`endif
    );

    modport slave (
        input  start, result, ack,
        output clear_votes, open, done, pass, fail, err, final_tally, elapsed
`ifdef VOTE_STATS_EN
        , output rise_cnt
`endif
    );

endinterface

// File: rtl/vote_window_cnt.sv
// ----------------------------------------------------------------------------
// vote_window_cnt
// 16-bit elapsed-cycle counter for the voting window.
//   clk, reset : clock, async active-high reset
//   clr        : synchronous clear (wins over en)
//   en         : count enable; counter saturates at 16'hFFFF
//   cnt        : current count
//   term       : cnt == WINDOW-1, i.e. the current cycle is the last allowed
// ----------------------------------------------------------------------------
module vote_window_cnt
    import vote_pkg::*;
#(
    parameter logic [CNT_W-1:0] WINDOW = 16'd1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             term
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != 16'hFFFF)) begin
            cnt <= cnt + 16'd1;
        end
    end

    assign term = (cnt == (WINDOW - 16'd1));

endmodule

// File: rtl/vote_session_ctrl.sv
// ----------------------------------------------------------------------------
// vote_session_ctrl
// Runs one weighted-vote session: clears the voter, opens a window of at most
// WINDOW cycles, decides pass (tally >= THRESH) or fail (timeout or tally
// decrease), and holds the verdict until the host acknowledges.
//   clk, reset : clock, async active-high reset
//   bus        : vote_session_ctrl_if.slave (start/result/ack in;
//                clear_votes/open/done/pass/fail/err/final_tally/elapsed out)
// Optional: define VOTE_STATS_EN to add bus.rise_cnt, the number of OPEN
// cycles in which the tally rose (saturating at 255).
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for start; verdict outputs held at 0
// ST_CLEAR | one cycle, clear_votes asserted, window counter cleared
// ST_OPEN  | evaluating the tally every cycle
// ST_DONE  | verdict, final_tally and elapsed frozen until ack
// ----------------------------------------------------------------------------
module vote_session_ctrl
    import vote_pkg::*;
#(
    parameter logic [TALLY_W-1:0] THRESH = 8'd41,
    parameter logic [CNT_W-1:0]   WINDOW = 16'd1000
) (
    input  logic               clk,
    input  logic               reset,
    vote_session_ctrl_if.slave bus
);

    if (WINDOW == 16'd0) begin : g_bad_window
        $error("vote_session_ctrl: WINDOW must be at least 1");
    end

    vote_state_t        state;
    logic [TALLY_W-1:0] prev_result;
    logic [TALLY_W-1:0] final_tally_q;
    logic               clear_q, open_q, done_q;
    logic               pass_q, fail_q, err_q;

    logic               cnt_clr, cnt_en, cnt_term;
    logic [CNT_W-1:0]   elapsed;
    logic               dropped, reached, decide;
    logic               acked;

    assign acked   = (state == ST_DONE) && bus.ack;
    assign cnt_clr = (state == ST_CLEAR) || acked;
    assign cnt_en  = (state == ST_OPEN);

    // Decision priority: a falling tally is an error even if it is still
    // above threshold; reaching threshold beats timeout on the same cycle.
    assign dropped = (bus.result < prev_result);
    assign reached = (bus.result >= THRESH);
    assign decide  = dropped || reached || cnt_term;

    vote_window_cnt #(.WINDOW(WINDOW)) u_window_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .cnt   (elapsed),
        .term  (cnt_term)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            prev_result   <= '0;
            final_tally_q <= '0;
            clear_q       <= 1'b0;
            open_q        <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            fail_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        state   <= ST_CLEAR;
                        clear_q <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    state       <= ST_OPEN;
                    clear_q     <= 1'b0;
                    open_q      <= 1'b1;
                    prev_result <= '0;
                end
                ST_OPEN: begin
                    prev_result <= bus.result;
                    if (decide) begin
                        state         <= ST_DONE;
                        open_q        <= 1'b0;
                        done_q        <= 1'b1;
                        final_tally_q <= bus.result;
                        err_q         <= dropped;
                        pass_q        <= !dropped && reached;
                        fail_q        <= dropped || !reached;
                    end
                end
                ST_DONE: begin
                    if (bus.ack) begin
                        state         <= ST_IDLE;
                        done_q        <= 1'b0;
                        pass_q        <= 1'b0;
                        fail_q        <= 1'b0;
                        err_q         <= 1'b0;
                        final_tally_q <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.clear_votes = clear_q;
    assign bus.open        = open_q;
    assign bus.done        = done_q;
    assign bus.pass        = pass_q;
    assign bus.fail        = fail_q;
    assign bus.err         = err_q;
    assign bus.final_tally = final_tally_q;
    assign bus.elapsed     = elapsed;

`ifdef VOTE_STATS_EN
    logic [7:0] rise_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rise_cnt_q <= '0;
        end else if (cnt_clr) begin
            rise_cnt_q <= '0;
        end else if ((state == ST_OPEN) && (bus.result > prev_result) &&
                     (rise_cnt_q != 8'hFF)) begin
            rise_cnt_q <= rise_cnt_q + 8'd1;
        end
    end

    assign bus.rise_cnt = rise_cnt_q;
`endif

endmodule

// File: tb/tb_vote_session_ctrl.sv
// ----------------------------------------------------------------------------
// tb_vote_session_ctrl
// Directed bench for vote_session_ctrl. dut_a: THRESH=41, WINDOW=10.
// dut_b: THRESH=100 (unreachable), WINDOW=1.
// ----------------------------------------------------------------------------
module tb_vote_session_ctrl;
    import vote_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;

    vote_session_ctrl_if bus_a ();
    vote_session_ctrl_if bus_b ();

    vote_session_ctrl #(.THRESH(8'd41), .WINDOW(16'd10)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    vote_session_ctrl #(.THRESH(8'd100), .WINDOW(16'd1)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    always #5 clk = ~clk;

    // {clear_votes, open, done} and {pass, fail, err}
    logic [2:0] ctl_a, vrd_a, ctl_b, vrd_b;
    assign ctl_a = {bus_a.clear_votes, bus_a.open, bus_a.done};
    assign vrd_a = {bus_a.pass, bus_a.fail, bus_a.err};
    assign ctl_b = {bus_b.clear_votes, bus_b.open, bus_b.done};
    assign vrd_b = {bus_b.pass, bus_b.fail, bus_b.err};

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        bus_a.start = 1'b0; bus_a.ack = 1'b0; bus_a.result = 8'd0;
        bus_b.start = 1'b0; bus_b.ack = 1'b0; bus_b.result = 8'd0;
        reset = 1'b1;
        step;
        step;
        n_vec++;
        if ({ctl_a, vrd_a} !== 6'b0) begin
            n_err++;
            $display("FAIL reset.flags_a got %b want 000000", {ctl_a, vrd_a});
        end
        n_vec++;
        if ({bus_a.final_tally, bus_a.elapsed} !== 24'd0) begin
            n_err++;
            $display("FAIL reset.data_a got tally=%0d elapsed=%0d want 0/0",
                     bus_a.final_tally, bus_a.elapsed);
        end
        n_vec++;
        if ({ctl_b, vrd_b} !== 6'b0) begin
            n_err++;
            $display("FAIL reset.flags_b got %b want 000000", {ctl_b, vrd_b});
        end
`ifdef VOTE_STATS_EN
        n_vec++;
        if (bus_a.rise_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL reset.rise_cnt got %0d want 0", bus_a.rise_cnt);
        end
`endif
        reset = 1'b0;
        step;
    endtask

    task automatic test_pass_path;
        logic [7:0] seq [5];
        seq = '{8'd0, 8'd0, 8'd0, 8'd20, 8'd41};
        bus_a.start = 1'b1;
        step;
        bus_a.start = 1'b0;
        n_vec++;
        if (ctl_a !== 3'b100) begin
            n_err++;
            $display("FAIL pass.clear_cycle got %b want 100", ctl_a);
        end
        step;
        n_vec++;
        if (ctl_a !== 3'b010) begin
            n_err++;
            $display("FAIL pass.open_entry got %b want 010", ctl_a);
        end
        for (int i = 0; i < 5; i++) begin
            bus_a.result = seq[i];
            step;
            if (i == 3) begin
                n_vec++;
                if ({ctl_a, bus_a.elapsed} !== {3'b010, 16'd4}) begin
                    n_err++;
                    $display("FAIL pass.still_open got ctl=%b elapsed=%0d want 010/4",
                             ctl_a, bus_a.elapsed);
                end
            end
        end
        n_vec++;
        if ({ctl_a, vrd_a} !== 6'b001_100) begin
            n_err++;
            $display("FAIL pass.verdict got %b want 001100", {ctl_a, vrd_a});
        end
        n_vec++;
        if (bus_a.final_tally !== 8'd41 || bus_a.elapsed !== 16'd5) begin
            n_err++;
            $display("FAIL pass.data got tally=%0d elapsed=%0d want 41/5",
                     bus_a.final_tally, bus_a.elapsed);
        end
        bus_a.ack = 1'b1;
        step;
        bus_a.ack = 1'b0;
        bus_a.result = 8'd0;
        n_vec++;
        if ({ctl_a, vrd_a, bus_a.final_tally, bus_a.elapsed} !== 30'd0) begin
            n_err++;
            $display("FAIL pass.ack_clear got ctl=%b vrd=%b tally=%0d elapsed=%0d want all 0",
                     ctl_a, vrd_a, bus_a.final_tally, bus_a.elapsed);
        end
    endtask

    task automatic test_timeout;
        bus_a.start = 1'b1;
        step;
        bus_a.start = 1'b0;
        step;
        bus_a.result = 8'd40;
        for (int i = 0; i < 9; i++) step;
        n_vec++;
        if ({ctl_a, bus_a.elapsed} !== {3'b010, 16'd9}) begin
            n_err++;
            $display("FAIL timeout.before got ctl=%b elapsed=%0d want 010/9",
                     ctl_a, bus_a.elapsed);
        end
        step;
        n_vec++;
        if ({ctl_a, vrd_a} !== 6'b001_010) begin
            n_err++;
            $display("FAIL timeout.verdict got %b want 001010", {ctl_a, vrd_a});
        end
        n_vec++;
        if (bus_a.final_tally !== 8'd40 || bus_a.elapsed !== 16'd10) begin
            n_err++;
            $display("FAIL timeout.data got tally=%0d elapsed=%0d want 40/10",
                     bus_a.final_tally, bus_a.elapsed);
        end
        bus_a.ack = 1'b1;
        step;
        bus_a.ack = 1'b0;
        bus_a.result = 8'd0;
        n_vec++;
        if ({ctl_a, vrd_a, bus_a.final_tally, bus_a.elapsed} !== 30'd0) begin
            n_err++;
            $display("FAIL timeout.ack_clear got ctl=%b vrd=%b tally=%0d elapsed=%0d want all 0",
                     ctl_a, vrd_a, bus_a.final_tally, bus_a.elapsed);
        end
    endtask

    task automatic test_priority;
        // threshold reached on the last window cycle: pass wins over timeout
        bus_a.start = 1'b1;
        step;
        bus_a.start = 1'b0;
        step;
        bus_a.result = 8'd0;
        for (int i = 0; i < 9; i++) step;
        bus_a.result = 8'd41;
        step;
        n_vec++;
        if ({ctl_a, vrd_a, bus_a.elapsed} !== {6'b001_100, 16'd10}) begin
            n_err++;
            $display("FAIL prio.pass_vs_timeout got ctl=%b vrd=%b elapsed=%0d want 001/100/10",
                     ctl_a, vrd_a, bus_a.elapsed);
        end
        bus_a.ack = 1'b1;
        step;
        bus_a.ack = 1'b0;
        // falling tally is an error
        bus_a.start = 1'b1;
        step;
        bus_a.start = 1'b0;
        step;
        bus_a.result = 8'd30;
        step;
        bus_a.result = 8'd25;
        step;
        n_vec++;
        if ({ctl_a, vrd_a} !== 6'b001_011) begin
            n_err++;
            $display("FAIL prio.err_verdict got %b want 001011", {ctl_a, vrd_a});
        end
        n_vec++;
        if (bus_a.final_tally !== 8'd25 || bus_a.elapsed !== 16'd2) begin
            n_err++;
            $display("FAIL prio.err_data got tally=%0d elapsed=%0d want 25/2",
                     bus_a.final_tally, bus_a.elapsed);
        end
        bus_a.ack = 1'b1;
        step;
        bus_a.ack = 1'b0;
        bus_a.result = 8'd0;
    endtask

    task automatic test_ignore_hold;
        bus_a.start = 1'b1;
        step;
        bus_a.start = 1'b0;
        step;
        bus_a.start = 1'b1;
        step;
        bus_a.start = 1'b0;
        n_vec++;
        if (ctl_a !== 3'b010) begin
            n_err++;
            $display("FAIL ignore.start_in_open got %b want 010", ctl_a);
        end
        bus_a.ack = 1'b1;
        step;
        bus_a.ack = 1'b0;
        n_vec++;
        if ({ctl_a, bus_a.elapsed} !== {3'b010, 16'd2}) begin
            n_err++;
            $display("FAIL ignore.ack_in_open got ctl=%b elapsed=%0d want 010/2",
                     ctl_a, bus_a.elapsed);
        end
        bus_a.result = 8'd41;
        step;
        bus_a.start = 1'b1;
        step;
        bus_a.start = 1'b0;
        n_vec++;
        if ({ctl_a, vrd_a} !== 6'b001_100) begin
            n_err++;
            $display("FAIL ignore.start_in_done got %b want 001100", {ctl_a, vrd_a});
        end
        bus_a.result = 8'd80;
        step;
        n_vec++;
        if (bus_a.final_tally !== 8'd41 || bus_a.elapsed !== 16'd3) begin
            n_err++;
            $display("FAIL ignore.hold got tally=%0d elapsed=%0d want 41/3",
                     bus_a.final_tally, bus_a.elapsed);
        end
        bus_a.start = 1'b1;
        bus_a.ack   = 1'b1;
        step;
        bus_a.start = 1'b0;
        bus_a.ack   = 1'b0;
        bus_a.result = 8'd0;
        n_vec++;
        if ({ctl_a, vrd_a} !== 6'b0) begin
            n_err++;
            $display("FAIL ignore.start_ack_done got %b want 000000", {ctl_a, vrd_a});
        end
        step;
        step;
        n_vec++;
        if (ctl_a !== 3'b000) begin
            n_err++;
            $display("FAIL ignore.no_restart got %b want 000", ctl_a);
        end
    endtask

    task automatic test_reset_mid_open;
        bus_a.start = 1'b1;
        step;
        bus_a.start = 1'b0;
        step;
        bus_a.result = 8'd10;
        for (int i = 0; i < 7; i++) step;
        n_vec++;
        if ({ctl_a, bus_a.elapsed} !== {3'b010, 16'd7}) begin
            n_err++;
            $display("FAIL rst_mid.pre got ctl=%b elapsed=%0d want 010/7",
                     ctl_a, bus_a.elapsed);
        end
        reset = 1'b1;
        #1;
        n_vec++;
        if ({ctl_a, vrd_a, bus_a.final_tally, bus_a.elapsed} !== 30'd0) begin
            n_err++;
            $display("FAIL rst_mid.async got ctl=%b vrd=%b tally=%0d elapsed=%0d want all 0",
                     ctl_a, vrd_a, bus_a.final_tally, bus_a.elapsed);
        end
        reset = 1'b0;
        bus_a.result = 8'd0;
        step;
        n_vec++;
        if (ctl_a !== 3'b000) begin
            n_err++;
            $display("FAIL rst_mid.idle got %b want 000", ctl_a);
        end
        bus_a.start = 1'b1;
        step;
        bus_a.start = 1'b0;
        step;
        step;
        step;
        bus_a.result = 8'd41;
        step;
        n_vec++;
        if ({ctl_a, vrd_a, bus_a.elapsed} !== {6'b001_100, 16'd3}) begin
            n_err++;
            $display("FAIL rst_mid.clean got ctl=%b vrd=%b elapsed=%0d want 001/100/3",
                     ctl_a, vrd_a, bus_a.elapsed);
        end
        bus_a.ack = 1'b1;
        step;
        bus_a.ack = 1'b0;
        bus_a.result = 8'd0;
    endtask

    task automatic test_window_one;
        bus_b.start = 1'b1;
        step;
        bus_b.start = 1'b0;
        step;
        bus_b.result = 8'd80;
        step;
        n_vec++;
        if ({ctl_b, vrd_b} !== 6'b001_010) begin
            n_err++;
            $display("FAIL win1.verdict got %b want 001010", {ctl_b, vrd_b});
        end
        n_vec++;
        if (bus_b.final_tally !== 8'd80 || bus_b.elapsed !== 16'd1) begin
            n_err++;
            $display("FAIL win1.data got tally=%0d elapsed=%0d want 80/1",
                     bus_b.final_tally, bus_b.elapsed);
        end
        bus_b.ack = 1'b1;
        step;
        bus_b.ack = 1'b0;
        bus_b.result = 8'd0;
    endtask

`ifdef VOTE_STATS_EN
    task automatic test_stats;
        logic [7:0] seq [5];
        seq = '{8'd0, 8'd4, 8'd4, 8'd20, 8'd36};
        bus_a.start = 1'b1;
        step;
        bus_a.start = 1'b0;
        step;
        for (int i = 0; i < 5; i++) begin
            bus_a.result = seq[i];
            step;
        end
        n_vec++;
        if ({ctl_a, bus_a.rise_cnt} !== {3'b010, 8'd3}) begin
            n_err++;
            $display("FAIL stats.open got ctl=%b rise=%0d want 010/3", ctl_a, bus_a.rise_cnt);
        end
        for (int i = 0; i < 5; i++) step;
        n_vec++;
        if ({ctl_a, vrd_a, bus_a.rise_cnt} !== {6'b001_010, 8'd3}) begin
            n_err++;
            $display("FAIL stats.done got ctl=%b vrd=%b rise=%0d want 001/010/3",
                     ctl_a, vrd_a, bus_a.rise_cnt);
        end
        bus_a.ack = 1'b1;
        step;
        bus_a.ack = 1'b0;
        bus_a.result = 8'd0;
        n_vec++;
        if (bus_a.rise_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL stats.ack_clear got %0d want 0", bus_a.rise_cnt);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_pass_path;
        test_timeout;
        test_priority;
        test_ignore_hold;
        test_reset_mid_open;
        test_window_one;
`ifdef VOTE_STATS_EN
        test_stats;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
